// File: rtl/div_2x1_1x1.sv
// ---------------------------------------------------------------------------
// div_2x1_1x1
// Sequential signed fixed-point divider: (A_00, A_10) / B -> (C_00, C_10).
// Both lanes run one radix-2 restoring iteration per cycle, in parallel,
// sharing the divisor magnitude and the iteration counter.
// Results truncate toward zero and saturate to the BIT_NUM range.
// Division by zero raises div_zero and forces max/min/zero by dividend sign.
//
// Optional build macro: DIV_ROUND_NEAREST_EN
//   When defined, one extra quotient bit is produced and used to round the
//   magnitude half away from zero. Saturation is applied after rounding.
//   This adds one cycle of latency.
// ---------------------------------------------------------------------------
module div_2x1_1x1 #(
   parameter int BIT_NUM  = 18,
   parameter int FRAC_NUM = 9
) (
   input  logic               clk,
   input  logic               srst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BIT_NUM-1:0] A_00,
   input  logic [BIT_NUM-1:0] A_10,
   input  logic [BIT_NUM-1:0] B,
   output logic [BIT_NUM-1:0] C_00,
   output logic [BIT_NUM-1:0] C_10,
   output logic               out_valid,
   output logic               div_zero
);

`ifdef DIV_ROUND_NEAREST_EN
   localparam int EXTRA_BITS = 1;
`else
   localparam int EXTRA_BITS = 0;
`endif

   // Number of quotient bits produced (= cycles spent in CALC).
   localparam int N_ITER = BIT_NUM + FRAC_NUM + EXTRA_BITS;
   localparam int CNT_W  = $clog2(N_ITER);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N_ITER - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   localparam logic [BIT_NUM-1:0] WORD_ZERO = {BIT_NUM{1'b0}};
   localparam logic [BIT_NUM-1:0] WORD_ONE  = {{(BIT_NUM-1){1'b0}}, 1'b1};
   localparam logic [BIT_NUM-1:0] WORD_MAX  = {1'b0, {(BIT_NUM-1){1'b1}}};
   localparam logic [BIT_NUM-1:0] WORD_MIN  = {1'b1, {(BIT_NUM-1){1'b0}}};

   // Magnitude limits expressed at quotient width.
   localparam logic [N_ITER-1:0] POS_LIM =
      {{(N_ITER-BIT_NUM+1){1'b0}}, {(BIT_NUM-1){1'b1}}};
   localparam logic [N_ITER-1:0] NEG_LIM =
      {{(N_ITER-BIT_NUM){1'b0}}, 1'b1, {(BIT_NUM-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Two's complement magnitude; the most negative value maps to 2^(BIT_NUM-1),
   // which is still representable as an unsigned BIT_NUM-bit number.
   function automatic logic [BIT_NUM-1:0] mag_of(input logic [BIT_NUM-1:0] v);
      if (v[BIT_NUM-1]) begin
         mag_of = (~v) + WORD_ONE;
      end else begin
         mag_of = v;
      end
   endfunction

   // One restoring step: returns {quotient_bit, next_remainder}.
   function automatic logic [BIT_NUM:0] div_step(
      input logic [BIT_NUM-1:0] rem,
      input logic               din,
      input logic [BIT_NUM-1:0] dsr
   );
      logic [BIT_NUM:0] shifted;
      logic [BIT_NUM:0] diff;
      shifted = {rem, din};
      diff    = shifted - {1'b0, dsr};
      if (shifted >= {1'b0, dsr}) begin
         div_step = {1'b1, diff[BIT_NUM-1:0]};
      end else begin
         div_step = {1'b0, shifted[BIT_NUM-1:0]};
      end
   endfunction

   // Turns the unsigned quotient into the final signed, saturated word.
   function automatic logic [BIT_NUM-1:0] finalize(
      input logic [N_ITER-1:0] q,
      input logic              res_neg,
      input logic              dz,
      input logic              a_neg,
      input logic              a_zero
   );
      logic [N_ITER-1:0] mag;
`ifdef DIV_ROUND_NEAREST_EN
      mag = {1'b0, q[N_ITER-1:1]} + {{(N_ITER-1){1'b0}}, q[0]};
`else
      mag = q;
`endif
      if (dz) begin
         if (a_zero) begin
            finalize = WORD_ZERO;
         end else if (a_neg) begin
            finalize = WORD_MIN;
         end else begin
            finalize = WORD_MAX;
         end
      end else if (!res_neg) begin
         finalize = (mag > POS_LIM) ? WORD_MAX : mag[BIT_NUM-1:0];
      end else begin
         finalize = (mag > NEG_LIM) ? WORD_MIN : ((~mag[BIT_NUM-1:0]) + WORD_ONE);
      end
   endfunction

   state_t             state_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [BIT_NUM-1:0] dsr_r;
   logic               dz_r;
   logic [N_ITER-1:0]  dvd0_r;
   logic [N_ITER-1:0]  dvd1_r;
   logic [BIT_NUM-1:0] rem0_r;
   logic [BIT_NUM-1:0] rem1_r;
   logic [N_ITER-1:0]  quo0_r;
   logic [N_ITER-1:0]  quo1_r;
   logic               neg0_r;
   logic               neg1_r;
   logic               a_neg0_r;
   logic               a_neg1_r;
   logic               a_zero0_r;
   logic               a_zero1_r;
   logic [BIT_NUM-1:0] c00_r;
   logic [BIT_NUM-1:0] c10_r;
   logic               out_valid_r;
   logic               div_zero_r;
   logic               in_ready_r;

   logic [BIT_NUM:0]   step0_s;
   logic [BIT_NUM:0]   step1_s;

   // Per-lane restoring step for the current CALC cycle.
   always_comb begin
      step0_s = {(BIT_NUM+1){1'b0}};
      step1_s = {(BIT_NUM+1){1'b0}};
      if (state_r == ST_CALC) begin
         step0_s = div_step(rem0_r, dvd0_r[N_ITER-1], dsr_r);
         step1_s = div_step(rem1_r, dvd1_r[N_ITER-1], dsr_r);
      end else begin
         step0_s = {(BIT_NUM+1){1'b0}};
         step1_s = {(BIT_NUM+1){1'b0}};
      end
   end

   // Control FSM, operand capture, iteration datapath and registered outputs.
   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= CNT_ZERO;
         dsr_r       <= WORD_ZERO;
         dz_r        <= 1'b0;
         dvd0_r      <= {N_ITER{1'b0}};
         dvd1_r      <= {N_ITER{1'b0}};
         rem0_r      <= WORD_ZERO;
         rem1_r      <= WORD_ZERO;
         quo0_r      <= {N_ITER{1'b0}};
         quo1_r      <= {N_ITER{1'b0}};
         neg0_r      <= 1'b0;
         neg1_r      <= 1'b0;
         a_neg0_r    <= 1'b0;
         a_neg1_r    <= 1'b0;
         a_zero0_r   <= 1'b0;
         a_zero1_r   <= 1'b0;
         c00_r       <= WORD_ZERO;
         c10_r       <= WORD_ZERO;
         out_valid_r <= 1'b0;
         div_zero_r  <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         out_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  dsr_r      <= mag_of(B);
                  dz_r       <= (B == WORD_ZERO);
                  dvd0_r     <= {mag_of(A_00), {(N_ITER-BIT_NUM){1'b0}}};
                  dvd1_r     <= {mag_of(A_10), {(N_ITER-BIT_NUM){1'b0}}};
                  rem0_r     <= WORD_ZERO;
                  rem1_r     <= WORD_ZERO;
                  quo0_r     <= {N_ITER{1'b0}};
                  quo1_r     <= {N_ITER{1'b0}};
                  neg0_r     <= A_00[BIT_NUM-1] ^ B[BIT_NUM-1];
                  neg1_r     <= A_10[BIT_NUM-1] ^ B[BIT_NUM-1];
                  a_neg0_r   <= A_00[BIT_NUM-1];
                  a_neg1_r   <= A_10[BIT_NUM-1];
                  a_zero0_r  <= (A_00 == WORD_ZERO);
                  a_zero1_r  <= (A_10 == WORD_ZERO);
                  cnt_r      <= CNT_LOAD;
                  in_ready_r <= 1'b0;
                  state_r    <= ST_CALC;
               end else begin
                  in_ready_r <= 1'b1;
                  state_r    <= ST_IDLE;
               end
            end
            ST_CALC: begin
               dvd0_r <= {dvd0_r[N_ITER-2:0], 1'b0};
               dvd1_r <= {dvd1_r[N_ITER-2:0], 1'b0};
               rem0_r <= step0_s[BIT_NUM-1:0];
               rem1_r <= step1_s[BIT_NUM-1:0];
               quo0_r <= {quo0_r[N_ITER-2:0], step0_s[BIT_NUM]};
               quo1_r <= {quo1_r[N_ITER-2:0], step1_s[BIT_NUM]};
               if (cnt_r == CNT_ZERO) begin
                  state_r <= ST_DONE;
               end else begin
                  cnt_r   <= cnt_r - CNT_ONE;
                  state_r <= ST_CALC;
               end
            end
            ST_DONE: begin
               c00_r       <= finalize(quo0_r, neg0_r, dz_r, a_neg0_r, a_zero0_r);
               c10_r       <= finalize(quo1_r, neg1_r, dz_r, a_neg1_r, a_zero1_r);
               div_zero_r  <= dz_r;
               out_valid_r <= 1'b1;
               in_ready_r  <= 1'b1;
               state_r     <= ST_IDLE;
            end
            default: begin
               in_ready_r <= 1'b1;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign C_00      = c00_r;
   assign C_10      = c10_r;
   assign out_valid = out_valid_r;
   assign div_zero  = div_zero_r;

endmodule
